// File: rtl/mac_opt.sv
// mac_opt: systolic-array processing element.
// Registered multiply-accumulate with operand forwarding to neighbours.
module mac_opt #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  control,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] wt_path_in,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] wt_path_out
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]  product_ext;
    logic [ACC_WIDTH-1:0]  sum;

    // Full-width unsigned product, zero-extended, then modulo add.
    always_comb begin
        product     = PROD_WIDTH'(data_in) * PROD_WIDTH'(wt_path_in);
        product_ext = ACC_WIDTH'(product);
        sum         = acc_in + product_ext;
    end

    // Output registers: clear on reset, load when enabled, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out     <= '0;
            data_out    <= '0;
            wt_path_out <= '0;
        end else if (control) begin
            acc_out     <= sum;
            data_out    <= data_in;
            wt_path_out <= wt_path_in;
        end
    end

endmodule

// File: tb/tb_mac_opt.sv
// tb_mac_opt: directed self-checking bench for mac_opt.
// Hand-computed vectors, immediate assertions at each check.
module tb_mac_opt;

    logic        clk;
    logic        reset;
    logic        control;
    logic [23:0] acc_in;
    logic [7:0]  data_in;
    logic [7:0]  wt_path_in;
    logic [23:0] acc_out;
    logic [7:0]  data_out;
    logic [7:0]  wt_path_out;

    int checks = 0;
    int errors = 0;

    mac_opt #(.DATA_WIDTH(8), .ACC_WIDTH(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .control    (control),
        .acc_in     (acc_in),
        .data_in    (data_in),
        .wt_path_in (wt_path_in),
        .acc_out    (acc_out),
        .data_out   (data_out),
        .wt_path_out(wt_path_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c, input logic [23:0] a,
                        input logic [7:0] d, input logic [7:0] w);
        control    = c;
        acc_in     = a;
        data_in    = d;
        wt_path_in = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        control    = 1'b0;
        acc_in     = '0;
        data_in    = '0;
        wt_path_in = '0;
        @(posedge clk);
        #1;
        chk("rst_acc", acc_out, 24'd0);
        chk("rst_data", {16'd0, data_out}, 24'd0);
        chk("rst_wt", {16'd0, wt_path_out}, 24'd0);
        reset = 1'b0;

        step(1'b1, 24'd0, 8'd3, 8'd4);
        chk("mac1_acc", acc_out, 24'd12);
        chk("mac1_data", {16'd0, data_out}, 24'd3);
        chk("mac1_wt", {16'd0, wt_path_out}, 24'd4);

        step(1'b1, 24'd12, 8'd5, 8'd6);
        chk("mac2_acc", acc_out, 24'd42);
        chk("mac2_data", {16'd0, data_out}, 24'd5);

        step(1'b0, 24'd42, 8'd7, 8'd8);
        chk("hold_acc", acc_out, 24'd42);
        chk("hold_data", {16'd0, data_out}, 24'd5);
        chk("hold_wt", {16'd0, wt_path_out}, 24'd6);

        // Outputs must not follow inputs between edges.
        control = 1'b1;
        acc_in  = 24'd100;
        data_in = 8'd9;
        #2;
        chk("no_comb_acc", acc_out, 24'd42);
        chk("no_comb_data", {16'd0, data_out}, 24'd5);

        // Asynchronous reset mid-cycle, over control=1.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_acc", acc_out, 24'd0);
        chk("async_data", {16'd0, data_out}, 24'd0);
        chk("async_wt", {16'd0, wt_path_out}, 24'd0);
        @(posedge clk);
        #1;
        chk("rst_prio_acc", acc_out, 24'd0);
        reset = 1'b0;

        step(1'b1, 24'd0, 8'd2, 8'd10);
        chk("post_rst_acc", acc_out, 24'd20);
        chk("post_rst_wt", {16'd0, wt_path_out}, 24'd10);

        step(1'b1, 24'hFFFFFF, 8'd1, 8'd1);
        chk("wrap_acc", acc_out, 24'h000000);

        step(1'b1, 24'd0, 8'd255, 8'd255);
        chk("max_acc", acc_out, 24'd65025);
        chk("max_data", {16'd0, data_out}, 24'd255);

        step(1'b1, 24'hFFFFFF, 8'd255, 8'd255);
        chk("max_wrap_acc", acc_out, 24'd65024);

        step(1'b1, 24'h00F000, 8'd16, 8'd16);
        chk("mid_acc", acc_out, 24'h00F100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
